// File: rtl/instr_encoder.sv
// Instruction encoder: packs decoded requests into 32-bit words and streams them to imem.
// Optional running XOR of written words: define INSTR_ENC_CHECKSUM_EN.
module instr_encoder #(
   parameter int ADDR_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              finish,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_class,
   input  logic [3:0]        req_alu_op,
   input  logic              req_imm,
   input  logic [31:0]       req_imm_val,
   input  logic              req_load,
   input  logic [3:0]        req_rn,
   input  logic [3:0]        req_rd,
   input  logic [3:0]        req_rm,
   input  logic [31:0]       req_offset,
   output logic              imem_valid,
   input  logic              imem_ready,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err_illegal,
   output logic              err_sticky,
   output logic [ADDR_W:0]   words_written,
   output logic [31:0]       checksum
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] FULL_CNT = FIFO_DEPTH[PW:0];

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   state_e            state_q;
   logic [31:0]       fifo_q [FIFO_DEPTH];
   logic [PW-1:0]     wptr_q, rptr_q;
   logic [PW:0]       cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W:0]   remaining_q, ww_q, remaining_d;
   logic              err_q, sticky_q;
   logic [31:0]       word_d;
   logic              legal_d, full, empty, accept, push, pop;

   assign full       = (cnt_q == FULL_CNT);
   assign empty      = (cnt_q == '0);
   assign req_ready  = (state_q == RUN) && !full && (remaining_q != '0);
   assign accept     = req_valid && req_ready;
   assign push       = accept && legal_d;
   assign pop        = !empty && imem_ready;
   assign remaining_d = {1'b1, {ADDR_W{1'b0}}} - {1'b0, base_addr};

   assign imem_valid    = !empty;
   assign imem_wdata    = fifo_q[rptr_q];
   assign imem_addr     = addr_q;
   assign busy          = (state_q == RUN) || (state_q == DRAIN);
   assign done          = (state_q == DONE);
   assign err_illegal   = err_q;
   assign err_sticky    = sticky_q;
   assign words_written = ww_q;

   always_comb begin
      word_d  = '0;
      legal_d = 1'b0;
      unique case (req_class)
         2'b00: begin
            legal_d = !(req_imm && |req_imm_val[31:8]);
            word_d  = {4'hE, 2'b00, req_imm, req_alu_op, 1'b0,
                       req_rn, req_rd, 12'h000};
            if (req_imm) word_d[7:0] = req_imm_val[7:0];
            else         word_d[3:0] = req_rm;
         end
         2'b01: begin
            legal_d = 1'b1;
            word_d  = {4'hE, 2'b01, 5'b0, req_load,
                       req_rn, req_rd, 12'h000};
         end
         2'b10: begin
            // offset must fit a signed 24-bit field
            legal_d = (&req_offset[31:23]) || !(|req_offset[31:23]);
            word_d  = {4'hE, 2'b10, 2'b00, req_offset[23:0]};
         end
         default: begin
            legal_d = 1'b0;
            word_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wptr_q] <= word_d;
   end

`ifdef INSTR_ENC_CHECKSUM_EN
   logic [31:0] cksum_q;
   always_ff @(posedge clk) begin
      if (rst)
         cksum_q <= '0;
      else if ((state_q == IDLE || state_q == DONE) && start)
         cksum_q <= '0;
      else if (pop)
         cksum_q <= cksum_q ^ fifo_q[rptr_q];
   end
   assign checksum = cksum_q;
`else
   assign checksum = 32'h0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wptr_q      <= '0;
         rptr_q      <= '0;
         cnt_q       <= '0;
         addr_q      <= '0;
         remaining_q <= '0;
         ww_q        <= '0;
         err_q       <= 1'b0;
         sticky_q    <= 1'b0;
      end else begin
         err_q <= accept && !legal_d;
         if (accept && !legal_d) sticky_q <= 1'b1;
         if (push) begin
            wptr_q      <= wptr_q + 1'b1;
            remaining_q <= remaining_q - 1'b1;
         end
         if (pop) begin
            rptr_q <= rptr_q + 1'b1;
            ww_q   <= ww_q + 1'b1;
            if (addr_q != '1) addr_q <= addr_q + 1'b1;
         end
         cnt_q <= cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
         unique case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q     <= RUN;
                  addr_q      <= base_addr;
                  ww_q        <= '0;
                  sticky_q    <= 1'b0;
                  remaining_q <= remaining_d;
               end
            end
            RUN: begin
               if (finish || (push && remaining_q == 1))
                  state_q <= DRAIN;
            end
            DRAIN: begin
               if (empty) state_q <= DONE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (ADDR_W=8 and ADDR_W=4 instances).
// Expected words are hand-encoded constants.
module tb_instr_encoder;

   logic        clk = 0;
   logic        rst = 1, start = 0, finish = 0, req_valid = 0, imem_ready = 0;
   logic [7:0]  base_addr = 0;
   logic [1:0]  req_class = 0;
   logic [3:0]  req_alu_op = 0, req_rn = 0, req_rd = 0, req_rm = 0;
   logic        req_imm = 0, req_load = 0;
   logic [31:0] req_imm_val = 0, req_offset = 0;
   logic        req_ready, imem_valid, busy, done, err_illegal, err_sticky;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata, checksum;
   logic [8:0]  words_written;

   logic        s_rst = 1, s_start = 0, s_req_valid = 0, s_imem_ready = 0;
   logic        s_finish = 0;
   logic [3:0]  s_base = 0;
   logic        s_req_ready, s_imem_valid, s_busy, s_done, s_err, s_sticky;
   logic [3:0]  s_imem_addr;
   logic [31:0] s_wdata, s_cksum;
   logic [4:0]  s_ww;

   int checks = 0;
   int errors = 0;
   logic [31:0] cap_d[$];
   logic [7:0]  cap_a[$];
   logic [3:0]  s_cap_a[$];
   logic [31:0] s_cap_d[$];
   logic [31:0] bp_words [4];
   logic [31:0] exp_ck;

   always #5 clk = ~clk;

   instr_encoder #(.ADDR_W(8), .FIFO_DEPTH(4)) u_dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .finish(finish), .req_valid(req_valid), .req_ready(req_ready),
      .req_class(req_class), .req_alu_op(req_alu_op), .req_imm(req_imm),
      .req_imm_val(req_imm_val), .req_load(req_load), .req_rn(req_rn),
      .req_rd(req_rd), .req_rm(req_rm), .req_offset(req_offset),
      .imem_valid(imem_valid), .imem_ready(imem_ready),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy),
      .done(done), .err_illegal(err_illegal), .err_sticky(err_sticky),
      .words_written(words_written), .checksum(checksum)
   );

   instr_encoder #(.ADDR_W(4), .FIFO_DEPTH(4)) u_small (
      .clk(clk), .rst(s_rst), .start(s_start), .base_addr(s_base),
      .finish(s_finish), .req_valid(s_req_valid), .req_ready(s_req_ready),
      .req_class(req_class), .req_alu_op(req_alu_op), .req_imm(req_imm),
      .req_imm_val(req_imm_val), .req_load(req_load), .req_rn(req_rn),
      .req_rd(req_rd), .req_rm(req_rm), .req_offset(req_offset),
      .imem_valid(s_imem_valid), .imem_ready(s_imem_ready),
      .imem_addr(s_imem_addr), .imem_wdata(s_wdata), .busy(s_busy),
      .done(s_done), .err_illegal(s_err), .err_sticky(s_sticky),
      .words_written(s_ww), .checksum(s_cksum)
   );

   always @(posedge clk) begin
      if (imem_valid && imem_ready) begin
         cap_d.push_back(imem_wdata);
         cap_a.push_back(imem_addr);
      end
      if (s_imem_valid && s_imem_ready) begin
         s_cap_d.push_back(s_wdata);
         s_cap_a.push_back(s_imem_addr);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input logic [1:0] cls, input logic [3:0] op,
                          input logic imm, input logic [31:0] iv,
                          input logic ld, input logic [3:0] rn,
                          input logic [3:0] rd, input logic [3:0] rm,
                          input logic [31:0] off);
      req_class = cls; req_alu_op = op; req_imm = imm; req_imm_val = iv;
      req_load = ld; req_rn = rn; req_rd = rd; req_rm = rm;
      req_offset = off;
   endtask

   task automatic send();
      int n;
      n = 0;
      req_valid = 1;
      #1;
      while (!req_ready && n < 50) begin
         tick();
         n++;
      end
      check("send_ready_timeout", {63'd0, req_ready}, 64'd1);
      tick();
      req_valid = 0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (!done && n < 50) begin
         tick();
         n++;
      end
      check(tag, {63'd0, done}, 64'd1);
   endtask

   initial begin
      int n;
      bp_words[0] = 32'hE0001002;
      bp_words[1] = 32'hE0212003;
      bp_words[2] = 32'hE0423004;
      bp_words[3] = 32'hE0634005;
      tick(); tick();
      rst = 0; s_rst = 0;
      tick();
      check("rst_busy", {63'd0, busy}, 0);
      check("rst_done", {63'd0, done}, 0);
      check("rst_valid", {63'd0, imem_valid}, 0);
      check("rst_addr", {56'd0, imem_addr}, 0);
      check("rst_ww", {55'd0, words_written}, 0);
      check("rst_ready", {63'd0, req_ready}, 0);
      check("rst_sticky", {63'd0, err_sticky}, 0);

      // small instance: capacity limit at the top of a 16-word memory
      set_req(2'b00, 4'b0100, 0, 0, 0, 4'd1, 4'd2, 4'd3, 0);
      s_imem_ready = 1; s_base = 4'd14; s_start = 1;
      tick();
      s_start = 0;
      check("s_ready_run", {63'd0, s_req_ready}, 1);
      s_req_valid = 1;
      tick(); tick();
      s_req_valid = 0;
      check("s_ready_full", {63'd0, s_req_ready}, 0);
      n = 0;
      while (!s_done && n < 50) begin tick(); n++; end
      check("s_done", {63'd0, s_done}, 1);
      check("s_ww", {59'd0, s_ww}, 2);
      check("s_ncap", s_cap_a.size(), 2);
      check("s_addr0", {60'd0, s_cap_a[0]}, 14);
      check("s_addr1", {60'd0, s_cap_a[1]}, 15);
      check("s_data1", {32'd0, s_cap_d[1]}, 32'hE0812003);

      // basic encodings, consecutive addresses from base 0
      imem_ready = 1; base_addr = 0; start = 1;
      tick();
      start = 0;
      check("run_busy", {63'd0, busy}, 1);
      set_req(2'b00, 4'b0100, 0, 0, 0, 4'd1, 4'd2, 4'd3, 0);
      send();
      tick();
      check("ww1", {55'd0, words_written}, 1);
      set_req(2'b00, 4'b1101, 1, 32'h2A, 0, 4'd0, 4'd5, 4'd0, 0);
      send();
      set_req(2'b01, 0, 0, 0, 1, 4'd1, 4'd4, 4'd0, 0);
      send();
      set_req(2'b10, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFE);
      send();
      tick(); tick();
      check("ncap4", cap_d.size(), 4);
      check("d0", {32'd0, cap_d[0]}, 32'hE0812003);
      check("d1", {32'd0, cap_d[1]}, 32'hE3A0502A);
      check("d2", {32'd0, cap_d[2]}, 32'hE4114000);
      check("d3", {32'd0, cap_d[3]}, 32'hE8FFFFFE);
      check("a0", {56'd0, cap_a[0]}, 0);
      check("a3", {56'd0, cap_a[3]}, 3);
      check("ww4", {55'd0, words_written}, 4);

      // illegal requests
      set_req(2'b00, 4'b1101, 1, 32'h100, 0, 0, 4'd5, 0, 0);
      send();
      check("ill_imm", {63'd0, err_illegal}, 1);
      check("sticky", {63'd0, err_sticky}, 1);
      set_req(2'b10, 0, 0, 0, 0, 0, 0, 0, 32'h00800000);
      send();
      check("ill_jmp", {63'd0, err_illegal}, 1);
      set_req(2'b11, 0, 0, 0, 0, 0, 0, 0, 0);
      send();
      check("ill_cls", {63'd0, err_illegal}, 1);
      tick(); tick();
      check("ill_pulse_end", {63'd0, err_illegal}, 0);
      check("ill_sticky", {63'd0, err_sticky}, 1);
      check("ill_ncap", cap_d.size(), 4);
      check("ill_ww", {55'd0, words_written}, 4);

      // backpressure: FIFO fills, head held stable
      imem_ready = 0;
      req_valid = 1;
      for (int i = 0; i < 4; i++) begin
         set_req(2'b00, 4'(i), 0, 0, 0, 4'(i), 4'(i + 1), 4'(i + 2), 0);
         #1;
         check("bp_ready", {63'd0, req_ready}, 1);
         tick();
      end
      set_req(2'b01, 0, 0, 0, 1, 4'd1, 4'd4, 0, 0);
      for (int i = 0; i < 6; i++) begin
         #1;
         check("bp_full", {63'd0, req_ready}, 0);
         check("bp_addr", {56'd0, imem_addr}, 4);
         check("bp_data", {32'd0, imem_wdata}, {32'd0, bp_words[0]});
         tick();
      end
      req_valid = 0;
      imem_ready = 1;
      tick(); tick(); tick(); tick(); tick();
      check("bp_ncap", cap_d.size(), 8);
      for (int i = 0; i < 4; i++) begin
         check("bp_wd", {32'd0, cap_d[4 + i]}, {32'd0, bp_words[i]});
         check("bp_wa", {56'd0, cap_a[4 + i]}, 64'(4 + i));
      end

      // finish mid-stream drains the FIFO
      imem_ready = 0;
      set_req(2'b01, 0, 0, 0, 1, 4'd1, 4'd4, 0, 0);
      send();
      set_req(2'b10, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFE);
      send();
      finish = 1;
      tick();
      finish = 0;
      check("drain_ready", {63'd0, req_ready}, 0);
      check("drain_busy", {63'd0, busy}, 1);
      check("drain_done", {63'd0, done}, 0);
      imem_ready = 1;
      wait_done("fin_done");
      check("fin_busy", {63'd0, busy}, 0);
      check("fin_ww", {55'd0, words_written}, 10);
      check("fin_d8", {32'd0, cap_d[8]}, 32'hE4114000);
      check("fin_a9", {56'd0, cap_a[9]}, 9);

      // restart from DONE and checksum
      base_addr = 8'h20; start = 1;
      tick();
      start = 0;
      check("re_ww", {55'd0, words_written}, 0);
      check("re_sticky", {63'd0, err_sticky}, 0);
      check("re_addr", {56'd0, imem_addr}, 64'h20);
      set_req(2'b00, 4'b0100, 0, 0, 0, 4'd1, 4'd2, 4'd3, 0);
      send();
      set_req(2'b00, 4'b1101, 1, 32'h2A, 0, 4'd0, 4'd5, 4'd0, 0);
      send();
      tick(); tick();
      check("ck_a11", {56'd0, cap_a[11]}, 64'h21);
`ifdef INSTR_ENC_CHECKSUM_EN
      exp_ck = 32'h03217029;
`else
      exp_ck = 32'h0;
`endif
      check("checksum", {32'd0, checksum}, {32'd0, exp_ck});

      // reset while draining drops the FIFO
      imem_ready = 0;
      set_req(2'b01, 0, 0, 0, 1, 4'd1, 4'd4, 0, 0);
      send();
      finish = 1;
      tick();
      finish = 0;
      check("rd_valid", {63'd0, imem_valid}, 1);
      rst = 1;
      tick();
      rst = 0;
      imem_ready = 1;
      check("rd_valid0", {63'd0, imem_valid}, 0);
      check("rd_busy", {63'd0, busy}, 0);
      check("rd_addr", {56'd0, imem_addr}, 0);
      tick(); tick();
      check("rd_ncap", cap_d.size(), 12);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encodes decoded instruction requests into the 32-bit instruction format consumed by the control unit: the encoder side of that decoder.
- Buffers encoded words in a small FIFO and streams them into instruction memory through a valid/ready write port at an auto-incrementing address.
- Used by the program loader and self-test sequencer to build programs in instruction memory.

Parameters:
- ADDR_W, 8, instruction memory word-address width; capacity is 2^ADDR_W words.
- FIFO_DEPTH, 4, encoded-word buffer depth; power of two, at least 2.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse; arms the encoder at base_addr (honoured in IDLE/DONE only)
- base_addr  input  ADDR_W  first write address, sampled with start
- finish  input  1  pulse; stop accepting requests, drain FIFO
- req_valid  input  1  request valid
- req_ready  output  1  request accepted when valid&ready
- req_class  input  2  00 ALU, 01 MEM, 10 JUMP, 11 illegal
- req_alu_op  input  4  ALU opcode
- req_imm  input  1  ALU operand2 is immediate
- req_imm_val  input  32  immediate value
- req_load  input  1  MEM: 1 = LDR, 0 = STR
- req_rn  input  4  base/first source register
- req_rd  input  4  destination (ALU/LDR) or store source (STR)
- req_rm  input  4  second source register
- req_offset  input  32  JUMP signed word offset
- imem_valid  output  1  write word valid
- imem_ready  input  1  memory accepts write
- imem_addr  output  ADDR_W  write address
- imem_wdata  output  32  encoded instruction
- busy  output  1  state is RUN or DRAIN
- done  output  1  level, state DONE
- err_illegal  output  1  one-cycle pulse per rejected request
- err_sticky  output  1  set by err_illegal, cleared by start or rst
- words_written  output  ADDR_W+1  words written since last start
- checksum  output  32  see Optional Feature

Behaviour:
- Reset: state IDLE, all outputs 0, FIFO empty, imem_addr 0.
- States:
  - IDLE: start -> RUN; imem_addr <- base_addr; words_written, err_sticky and checksum cleared; remaining <- 2^ADDR_W - base_addr.
  - RUN: finish, or remaining reaching 0 on an accept -> DRAIN.
  - DRAIN: FIFO empty -> DONE.
  - DONE: start -> RUN, identical to IDLE.
  - start is ignored in RUN and DRAIN. finish is ignored outside RUN.
- req_ready = (state==RUN) && FIFO not full && remaining>0. It is combinational and does not depend on req_valid.
- Encoding (combinational on request fields):
  - [31:28] = 4'hE; unused bits are 0.
  - ALU: [27:26]=00, [25]=req_imm, [24:21]=alu_op, [20]=0, [19:16]=rn, [15:12]=rd. If imm: [7:0]=imm_val[7:0]; else [3:0]=rm.
  - MEM: [27:26]=01, [25:21]=0, [20]=load, [19:16]=rn, [15:12]=rd.
  - JUMP: [27:26]=10, [25:24]=0, [23:0]=offset[23:0].
- Legality:
  - Illegal if class 11, or ALU immediate with imm_val > 255, or JUMP offset outside -2^23..2^23-1 (offset[31:23] not all equal).
  - An accepted illegal request is consumed but not pushed: err_illegal pulses the next cycle, and remaining is not decremented.
  - A legal accept pushes one word and decrements remaining.
- Write side:
  - imem_valid = FIFO not empty; imem_wdata = FIFO head; imem_addr = current write address.
  - imem_wdata and imem_addr are held stable while valid && !ready.
  - On valid && ready: pop, address +1, words_written +1.
- Push and pop in the same cycle with the FIFO full is permitted for the pop only; req_ready still reflects full, so no push occurs that cycle.
- Latency: a legal accept at cycle N gives imem_valid at N+1 when the FIFO was empty.
- Capacity: the address never wraps; the last write goes to 2^ADDR_W-1.
- rst mid-operation drops FIFO contents and returns to IDLE. No partial write is issued after rst.

Optional Feature:
- Macro INSTR_ENC_CHECKSUM_EN.
- Defined: checksum = running XOR of every word actually written (on valid && ready), cleared on start.
- Undefined: checksum is tied to 32'h0 and no checksum logic exists.

Test Plan:
- start base 0; ALU reg op=0100 rn=1 rd=2 rm=3 -> write addr 0, data 0xE0812003; words_written=1.
- ALU imm op=1101 rd=5 rn=0 imm=0x2A -> 0xE3A0502A. LDR rn=1 rd=4 -> 0xE4114000. JUMP offset -2 -> 0xE8FFFFFE. Addresses are consecutive.
- ALU imm=0x100, JUMP offset 0x00800000, class 11 -> three err_illegal pulses, err_sticky=1, no writes, words_written unchanged.
- imem_ready held 0 for 10 cycles while 6 requests are offered -> 4 accepted then req_ready=0; data and addr stable; all 4 written in order once ready=1.
- ADDR_W=4, base 14 -> 2 words written to 14,15, then req_ready=0 -> DRAIN -> done=1. finish mid-stream drains the FIFO and then sets done. rst while DRAIN -> IDLE, imem_valid=0 the next cycle.
- With INSTR_ENC_CHECKSUM_EN, writing 0xE0812003 then 0xE3A0502A -> checksum 0x03217029.
